up_down_counter_mod: RTL and testbench

Parametrised up/down counter with runtime modulus, step size, parallel load, synchronous clear and selectable wrap or saturate behaviour. It generalises the team's basic enable/direction counter for timer, address-generator and PWM-period use. Status outputs are registered one-cycle pulses or decodes of the count register. The block is a single-clock leaf with no handshakes.

---
 rtl/up_down_counter_mod.sv | 103 ++++++++++
 tb/tb_up_down_counter_mod.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/up_down_counter_mod.sv
// Up/down counter with runtime modulus (0..limit), step size, parallel load,
// synchronous clear and wrap/saturate selection; registered wrap/sat pulses.
module up_down_counter_mod #(
    parameter int BITS      = 8,
    parameter int STEP_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 up,
    input  logic [STEP_BITS-1:0] step,
    input  logic [BITS-1:0]      limit,
    input  logic                 saturate,
    input  logic                 clear,
    input  logic                 load,
    input  logic [BITS-1:0]      load_val,
    output logic [BITS-1:0]      Q,
    output logic                 wrap_pulse,
    output logic                 sat_pulse,
    output logic                 at_max,
    output logic                 at_zero
);

    localparam int W = BITS + 1;

    logic [BITS-1:0] r_q;
    logic            r_wrap;
    logic            r_sat;

    logic [W-1:0]    w_q, w_lim, w_lim1, w_step, w_sum, w_nxt;
    logic [BITS-1:0] w_load;
    logic            w_nwrap, w_nsat;

    // One extra bit of headroom so Q+step and Q+limit+1 never overflow.
    assign w_q    = {1'b0, r_q};
    assign w_lim  = {1'b0, limit};
    assign w_lim1 = w_lim + W'(1);
    assign w_step = W'(step);
    assign w_sum  = w_q + w_step;
    assign w_load = (load_val > limit) ? limit : load_val;

    always_comb begin
        w_nxt   = w_q;
        w_nwrap = 1'b0;
        w_nsat  = 1'b0;
        if (w_q > w_lim) begin
            // limit was lowered below Q: pull back silently, ignore step
            w_nxt = w_lim;
        end else if (w_step != '0) begin
            if (up) begin
                if (w_sum <= w_lim) begin
                    w_nxt = w_sum;
                end else if (saturate) begin
                    w_nxt  = w_lim;
                    w_nsat = 1'b1;
                end else begin
                    w_nwrap = 1'b1;
                    w_nxt   = (w_step <= w_lim1) ? (w_sum - w_lim1) : '0;
                end
            end else begin
                if (w_step <= w_q) begin
                    w_nxt = w_q - w_step;
                end else if (saturate) begin
                    w_nxt  = '0;
                    w_nsat = 1'b1;
                end else begin
                    w_nwrap = 1'b1;
                    w_nxt   = (w_step <= w_lim1) ? (w_q + w_lim1 - w_step) : w_lim;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else if (clear) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else if (load) begin
            r_q    <= w_load;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else if (enable) begin
            r_q    <= w_nxt[BITS-1:0];
            r_wrap <= w_nwrap;
            r_sat  <= w_nsat;
        end else begin
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end
    end

    assign Q          = r_q;
    assign wrap_pulse = r_wrap;
    assign sat_pulse  = r_sat;
    assign at_max     = (r_q == limit);
    assign at_zero    = (r_q == '0);

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed table-driven bench for up_down_counter_mod (BITS=8, STEP_BITS=4),
// plus hand sequences for combinational decode and asynchronous reset.
module tb_up_down_counter_mod;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable, up, saturate, clear, load;
    logic [3:0] step;
    logic [7:0] limit, load_val;
    logic [7:0] Q;
    logic       wrap_pulse, sat_pulse, at_max, at_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       c, l;
        logic [7:0] lv;
        logic       en, u;
        logic [3:0] st;
        logic [7:0] lim;
        logic       sat;
        logic [7:0] eq;
        logic       ew, es;
    } vec_t;

    vec_t vecs[$];

    up_down_counter_mod #(.BITS(8), .STEP_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .step(step),
        .limit(limit), .saturate(saturate), .clear(clear), .load(load),
        .load_val(load_val), .Q(Q), .wrap_pulse(wrap_pulse), .sat_pulse(sat_pulse),
        .at_max(at_max), .at_zero(at_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic v(input logic c, input logic l, input logic [7:0] lv,
                     input logic en, input logic u, input logic [3:0] st,
                     input logic [7:0] lim, input logic sat,
                     input logic [7:0] eq, input logic ew, input logic es);
        vec_t t;
        t.c = c; t.l = l; t.lv = lv; t.en = en; t.u = u; t.st = st;
        t.lim = lim; t.sat = sat; t.eq = eq; t.ew = ew; t.es = es;
        vecs.push_back(t);
    endtask

    initial begin
        reset_n = 1'b0; enable = 0; up = 1; saturate = 0; clear = 0; load = 0;
        step = 4'd1; limit = 8'd9; load_val = 8'd0;

        // wrap mod 10, step 1 up from reset
        for (int i = 1; i <= 12; i++)
            v(0,0,0, 1,1,4'd1, 8'd9,0, 8'(i % 10), i == 10, 0);
        // step 4 down wrap from 2
        v(0,1,8'd2,   0,0,4'd4, 8'd9,0, 8'd2, 0,0);
        v(0,0,0,      1,0,4'd4, 8'd9,0, 8'd8, 1,0);
        v(0,0,0,      1,0,4'd4, 8'd9,0, 8'd4, 0,0);
        v(0,0,0,      1,0,4'd4, 8'd9,0, 8'd0, 0,0);
        v(0,0,0,      1,0,4'd4, 8'd9,0, 8'd6, 1,0);
        // saturate at 200 with step 15, then count down
        v(0,1,8'd190, 0,1,4'd15, 8'd200,1, 8'd190, 0,0);
        v(0,0,0,      1,1,4'd15, 8'd200,1, 8'd200, 0,1);
        v(0,0,0,      1,1,4'd15, 8'd200,1, 8'd200, 0,1);
        v(0,0,0,      1,1,4'd15, 8'd200,1, 8'd200, 0,1);
        v(0,0,0,      1,0,4'd15, 8'd200,1, 8'd185, 0,0);
        // runtime limit drop below Q, and load clamp
        v(0,1,8'd50,  0,1,4'd1, 8'd200,0, 8'd50, 0,0);
        v(0,0,0,      1,1,4'd1, 8'd20,0,  8'd20, 0,0);
        v(0,1,8'd30,  1,1,4'd1, 8'd20,0,  8'd20, 0,0);
        // step 0 holds, enable low clears pulse
        v(0,0,0,      1,1,4'd1, 8'd20,0,  8'd0,  1,0);
        v(0,0,0,      1,1,4'd0, 8'd20,0,  8'd0,  0,0);
        v(0,0,0,      1,0,4'd1, 8'd20,1,  8'd0,  0,1);
        v(0,0,0,      0,0,4'd1, 8'd20,1,  8'd0,  0,0);
        // limit 0: pinned at zero, pulses by mode
        v(0,1,8'd9,   0,1,4'd3, 8'd0,0, 8'd0, 0,0);
        v(0,0,0,      1,1,4'd3, 8'd0,0, 8'd0, 1,0);
        v(0,0,0,      1,1,4'd3, 8'd0,1, 8'd0, 0,1);
        v(0,0,0,      1,0,4'd1, 8'd0,0, 8'd0, 1,0);
        // full range modulo 256
        v(0,1,8'd255, 0,1,4'd1, 8'd255,0, 8'd255, 0,0);
        v(0,0,0,      1,1,4'd1, 8'd255,0, 8'd0,   1,0);
        v(0,0,0,      1,0,4'd1, 8'd255,0, 8'd255, 1,0);
        // step larger than modulus, and in-range down wrap
        v(0,1,8'd1,   0,1,4'd15, 8'd3,0, 8'd1, 0,0);
        v(0,0,0,      1,1,4'd15, 8'd3,0, 8'd0, 1,0);
        v(0,1,8'd1,   0,0,4'd15, 8'd3,0, 8'd1, 0,0);
        v(0,0,0,      1,0,4'd15, 8'd3,0, 8'd3, 1,0);
        v(0,1,8'd1,   0,0,4'd2,  8'd3,0, 8'd1, 0,0);
        v(0,0,0,      1,0,4'd2,  8'd3,0, 8'd3, 1,0);
        // clear beats load and enable; then load and hold with enable low
        v(1,1,8'd7,   1,1,4'd1, 8'd9,0, 8'd0, 0,0);
        v(0,1,8'd7,   0,1,4'd1, 8'd9,0, 8'd7, 0,0);
        v(0,0,0,      0,0,4'd5, 8'd9,1, 8'd7, 0,0);
        v(0,0,0,      0,1,4'd9, 8'd9,0, 8'd7, 0,0);

        #12;
        check("rst_q", Q, 0);
        check("rst_wrap", wrap_pulse, 0);
        check("rst_sat", sat_pulse, 0);
        check("rst_at_zero", at_zero, 1);
        check("rst_at_max", at_max, 0);
        limit = 8'd0; #1;
        check("rst_at_max_lim0", at_max, 1);
        limit = 8'd9;
        @(negedge clk); reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            clear = vecs[i].c; load = vecs[i].l; load_val = vecs[i].lv;
            enable = vecs[i].en; up = vecs[i].u; step = vecs[i].st;
            limit = vecs[i].lim; saturate = vecs[i].sat;
            @(posedge clk); #1;
            check($sformatf("v%0d_q", i), Q, vecs[i].eq);
            check($sformatf("v%0d_wrap", i), wrap_pulse, vecs[i].ew);
            check($sformatf("v%0d_sat", i), sat_pulse, vecs[i].es);
            check($sformatf("v%0d_at_max", i), at_max, vecs[i].eq == vecs[i].lim);
            check($sformatf("v%0d_at_zero", i), at_zero, vecs[i].eq == 0);
        end

        // at_max follows a limit change with no clock edge (Q=7, enable low)
        @(negedge clk);
        clear = 0; load = 0; enable = 0; limit = 8'd7; #1;
        check("comb_at_max_hit", at_max, 1);
        limit = 8'd8; #1;
        check("comb_at_max_miss", at_max, 0);

        // asynchronous reset between edges at Q=5
        @(negedge clk);
        clear = 1; limit = 8'd9; step = 4'd1; up = 1; saturate = 0;
        @(negedge clk);
        clear = 0; enable = 1;
        repeat (5) @(posedge clk);
        #1 check("pre_rst_q", Q, 5);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_q", Q, 0);
        check("async_rst_wrap", wrap_pulse, 0);
        check("async_rst_sat", sat_pulse, 0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("resume_q", Q, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
